muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit for the EX stage; replaces the combinational
//  mult path and separate divider. Signed/unsigned MULT, DIV and new accumulate modes
//  MADD/MADDU/MSUB/MSUBU against a HI/LO snapshot. Drives a pipeline stall while busy and
//  returns a {HI,LO} result with a one-cycle done pulse.
// PARAMETERS
//  WIDTH       32  operand width; result is 2*WIDTH ({HI,LO})
//  MUL_STAGES  2   multiplier pipeline depth in cycles (>=1)
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-low
//  start        in   1        request; sampled only in IDLE
//  op           in   3        0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU
//  a            in   WIDTH    rs operand (dividend / multiplicand)
//  b            in   WIDTH    rt operand (divisor / multiplier)
//  hilo_in      in   2*WIDTH  current {HI,LO}; accumulate base
//  flush        in   1        cancel in-flight op (EX flush)
//  stall        out  1        hold pipeline
//  busy         out  1        state != IDLE
//  done         out  1        one-cycle pulse, result valid
//  result       out  2*WIDTH  {HI,LO}
//  div_by_zero  out  1        pulse with done when DIV/DIVU had b==0
// BEHAVIOUR
//  Reset (rst low, async): state IDLE; result, done, div_by_zero, busy = 0.
//  FSM: IDLE -> MUL | DIV -> DONE -> IDLE. In IDLE with start & ~flush, latch op, a, b, hilo_in.
//  stall = (start & IDLE & ~flush) | MUL | DIV. Low in DONE so the instruction advances that cycle.
//  start in MUL/DIV/DONE ignored (same instruction held in EX); no queueing.
//  MUL: product valid after MUL_STAGES cycles in MUL; done asserted in the following (DONE) cycle.
//   Signed ops sign-extend to 2*WIDTH; unsigned zero-extend. Full 2*WIDTH product, no overflow.
//   MADD*: result = hilo_snapshot + product; MSUB*: hilo_snapshot - product; mod 2^(2*WIDTH).
//  DIV: 1 prep cycle (abs values for signed), WIDTH restoring radix-2 iterations, 1 sign-fix cycle;
//   done in cycle WIDTH+2 after start (34 for WIDTH=32). result = {remainder, quotient}.
//   Signed: quotient sign = a^b sign, remainder takes sign of a.
//   -2^(W-1) / -1: quotient 0x8000_0000, remainder 0 (wrap, no exception).
//   b==0: skip iterations, go to DONE after prep; result = {a, all-ones}; div_by_zero=1 with done.
//  flush: synchronous, highest priority; any state -> IDLE next cycle, no done, result unchanged.
//   flush & start in IDLE: request dropped.
//  done/div_by_zero high exactly one cycle; result holds until next done or reset.
//  Reset mid-operation: immediate return to IDLE, outputs cleared.
// STRUCTURE
//  Op encodings as `MD_OP_* and state encodings in defines.vh (shared with decoder/ALU control).
//  Sub-module div_radix2: WIDTH-iteration unsigned shift-subtract core (start, dividend, divisor,
//  flush -> quotient, remainder, valid). Multiplier pipeline and accumulate adder stay in top.
// TESTING
//  MULT a=-3 b=7, MUL_STAGES=2 -> done 3rd cycle after start, result 0xFFFFFFFF_FFFFFFEB, stall low in DONE.
//  DIV a=-7 b=2 -> done cycle 34, result 0xFFFFFFFF_FFFFFFFD; DIVU 0xFFFFFFFF/0x10 -> 0x0000000F_0FFFFFFF.
//  DIV b=0, a=0x1234 -> result 0x00001234_FFFFFFFF, div_by_zero pulse with done, ~3 cycles.
//  MADD hilo_in=0x0000_0010 a=2 b=3 -> 0x16; MSUBU hilo_in=0 a=1 b=1 -> 0xFFFFFFFF_FFFFFFFF.
//  flush at cycle 10 of DIV -> busy/stall low next cycle, no done; next DIVU 100/7 -> 0x2_0000000E.
//  rst low mid-MUL -> all outputs 0 asynchronously; start held through DONE -> exactly one done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and decode helpers for the EX-stage multiply/divide unit.
// Kept in one place so decoder and ALU control agree on the operation numbering.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MADD  = 3'd4,
        MD_OP_MADDU = 3'd5,
        MD_OP_MSUB  = 3'd6,
        MD_OP_MSUBU = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Even encodings are the signed flavours.
    function automatic logic is_signed_op(input md_op_e op);
        return ~op[0];
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic is_madd_op(input md_op_e op);
        return (op == MD_OP_MADD) || (op == MD_OP_MADDU);
    endfunction

    function automatic logic is_msub_op(input md_op_e op);
        return (op == MD_OP_MSUB) || (op == MD_OP_MSUBU);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// Unsigned restoring radix-2 divider core: one quotient bit per cycle, WIDTH cycles.
// valid is raised during the final iteration; quotient/remainder then carry that iteration's result.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    // One shift-subtract step; a borrow out of the trial keeps the shifted remainder.
    always_comb begin
        trial_s = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};
        if (trial_s[WIDTH]) begin
            rem_next_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

    // Iteration state: load on start, step while the counter is non-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
            dvs_r <= {WIDTH{1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (flush) begin
            cnt_r <= CNT_ZERO;
        end else if (start) begin
            rem_r <= {WIDTH{1'b0}};
            quo_r <= dividend;
            dvs_r <= divisor;
            cnt_r <= CNT_FULL;
        end else if (cnt_r != CNT_ZERO) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    assign quotient  = quo_next_s;
    assign remainder = rem_next_s;
    assign valid     = (cnt_r == CNT_ONE);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / divide / multiply-accumulate unit for the EX stage.
// Holds the pipeline while working and returns {HI,LO} with a one-cycle done pulse.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] hilo_in,
    input  logic               flush,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);
    localparam int MUL_CNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_ZERO = {MUL_CNT_W{1'b0}};
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_ONE  = {{(MUL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_INIT = MUL_CNT_W'(MUL_STAGES - 1);
    localparam logic [WIDTH-1:0]     ZERO_W       = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     ONE_W        = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
        return c ? (~v + ONE_W) : v;
    endfunction

    md_state_e              state_r, state_next_s;
    md_op_e                 op_r;
    logic [WIDTH-1:0]       a_r, b_r;
    logic [2*WIDTH-1:0]     hilo_r;
    logic [MUL_CNT_W-1:0]   mul_cnt_r;
    logic                   div_prep_r;
    logic [2*WIDTH-1:0]     result_r;
    logic                   done_r, dz_r;

    logic                   accept_s, mul_last_s, div_zero_s, div_start_s;
    logic                   sign_a_s, sign_b_s;
    logic [WIDTH-1:0]       abs_a_s, abs_b_s, quo_raw_s, rem_raw_s, quo_fix_s, rem_fix_s;
    logic                   div_valid_s;
    logic [2*WIDTH-1:0]     ext_a_s, ext_b_s, product_s, mul_final_s, mul_result_s;

    assign accept_s   = start & (state_r == ST_IDLE) & ~flush;
    assign mul_last_s = (state_r == ST_MUL) && (mul_cnt_r == MUL_CNT_ZERO);
    assign div_zero_s = (b_r == ZERO_W);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state; flush beats everything, including a same-cycle start.
    always_comb begin
        state_next_s = state_r;
        div_start_s  = 1'b0;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = is_div_op(md_op_e'(op)) ? ST_DIV : ST_MUL;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (mul_cnt_r == MUL_CNT_ZERO) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (div_prep_r) begin
                        if (div_zero_s) begin
                            state_next_s = ST_DONE;
                        end else begin
                            div_start_s  = 1'b1;
                            state_next_s = ST_DIV;
                        end
                    end else if (div_valid_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DIV;
                    end
                end
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Operand snapshot and per-op sequencing counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r       <= MD_OP_MULT;
            a_r        <= ZERO_W;
            b_r        <= ZERO_W;
            hilo_r     <= {(2*WIDTH){1'b0}};
            mul_cnt_r  <= MUL_CNT_ZERO;
            div_prep_r <= 1'b0;
        end else begin
            div_prep_r <= accept_s & is_div_op(md_op_e'(op));
            if (accept_s) begin
                op_r      <= md_op_e'(op);
                a_r       <= a;
                b_r       <= b;
                hilo_r    <= hilo_in;
                mul_cnt_r <= MUL_CNT_INIT;
            end else if ((state_r == ST_MUL) && (mul_cnt_r != MUL_CNT_ZERO)) begin
                mul_cnt_r <= mul_cnt_r - MUL_CNT_ONE;
            end
        end
    end

    // Sign handling around the unsigned divider core and the extended multiplier operands.
    always_comb begin
        sign_a_s  = is_signed_op(op_r) & a_r[WIDTH-1];
        sign_b_s  = is_signed_op(op_r) & b_r[WIDTH-1];
        abs_a_s   = neg_if(a_r, sign_a_s);
        abs_b_s   = neg_if(b_r, sign_b_s);
        quo_fix_s = neg_if(quo_raw_s, sign_a_s ^ sign_b_s);
        rem_fix_s = neg_if(rem_raw_s, sign_a_s);
        if (is_signed_op(op_r)) begin
            ext_a_s = {{WIDTH{a_r[WIDTH-1]}}, a_r};
            ext_b_s = {{WIDTH{b_r[WIDTH-1]}}, b_r};
        end else begin
            ext_a_s = {ZERO_W, a_r};
            ext_b_s = {ZERO_W, b_r};
        end
        product_s = ext_a_s * ext_b_s;
    end

    div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .flush     (flush),
        .dividend  (abs_a_s),
        .divisor   (abs_b_s),
        .quotient  (quo_raw_s),
        .remainder (rem_raw_s),
        .valid     (div_valid_s)
    );

    if (MUL_STAGES > 1) begin : g_mul_pipe
        logic [2*WIDTH-1:0] pipe_r [MUL_STAGES-1];
        // Retiming chain behind the product so the multiplier spans MUL_STAGES cycles.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < MUL_STAGES - 1; i++) pipe_r[i] <= {(2*WIDTH){1'b0}};
            end else begin
                pipe_r[0] <= product_s;
                for (int i = 1; i < MUL_STAGES - 1; i++) pipe_r[i] <= pipe_r[i-1];
            end
        end
        assign mul_final_s = pipe_r[MUL_STAGES-2];
    end else begin : g_mul_comb
        assign mul_final_s = product_s;
    end

    // Accumulate against the HI/LO snapshot, wrapping mod 2^(2*WIDTH).
    always_comb begin
        if (is_madd_op(op_r)) begin
            mul_result_s = hilo_r + mul_final_s;
        end else if (is_msub_op(op_r)) begin
            mul_result_s = hilo_r - mul_final_s;
        end else begin
            mul_result_s = mul_final_s;
        end
    end

    // Registered result and single-cycle status pulses; a flush suppresses completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= {(2*WIDTH){1'b0}};
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            if (!flush) begin
                if (mul_last_s) begin
                    result_r <= mul_result_s;
                    done_r   <= 1'b1;
                end else if ((state_r == ST_DIV) && div_prep_r && div_zero_s) begin
                    result_r <= {a_r, {WIDTH{1'b1}}};
                    done_r   <= 1'b1;
                    dz_r     <= 1'b1;
                end else if ((state_r == ST_DIV) && !div_prep_r && div_valid_s) begin
                    result_r <= {rem_fix_s, quo_fix_s};
                    done_r   <= 1'b1;
                end
            end
        end
    end

    assign stall       = accept_s | (state_r == ST_MUL) | (state_r == ST_DIV);
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;
    assign div_by_zero = dz_r;
    assign result      = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, queued expectations,
// and a monitor that checks result, div_by_zero, latency and stall on every done pulse.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [63:0] hilo_in = 64'd0;
    logic        flush = 1'b0;
    logic        stall, busy, done, div_by_zero;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   done_cnt = 0;

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hilo_in(hilo_in), .flush(flush), .stall(stall), .busy(busy),
        .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic [63:0] h);
        exp_t        e;
        logic [63:0] sp, up;
        logic [31:0] q, r;
        int          sx, sy;
        sp = longint'($signed(x)) * longint'($signed(y));
        up = {32'd0, x} * {32'd0, y};
        sx = x;
        sy = y;
        e.dz  = 1'b0;
        e.lat = 3;
        e.t0  = 0;
        case (o)
            3'd0: e.res = sp;
            3'd1: e.res = up;
            3'd4: e.res = h + sp;
            3'd5: e.res = h + up;
            3'd6: e.res = h - sp;
            3'd7: e.res = h - up;
            default: begin
                if (y == 32'd0) begin
                    e.res = {x, 32'hFFFF_FFFF};
                    e.dz  = 1'b1;
                    e.lat = 2;
                end else begin
                    e.lat = 34;
                    if (o == 3'd3) begin
                        q = x / y;
                        r = x % y;
                    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        q = 32'h8000_0000;
                        r = 32'd0;
                    end else begin
                        q = sx / sy;
                        r = sx % sy;
                    end
                    e.res = {r, q};
                end
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] h, input bit push, input bit hold,
                         input bit use_k = 1'b0, input logic [63:0] k_res = 64'd0);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1; op = o; a = x; b = y; hilo_in = h;
        if (push) begin
            e = model(o, x, y, h);
            if (use_k) e.res = k_res;
            e.t0 = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check("stall_on_start", 64'(stall), 64'd1);
        if (!hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1, required no done");
            end else begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.res);
                check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
                check("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                check("stall_in_done", 64'(stall), 64'd0);
            end
        end
    end

    initial begin
        int d0, n;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_result", result, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB); drain();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD); drain();
        issue(3'd3, 32'hFFFF_FFFF, 32'h10, 64'd0, 1, 0, 1, 64'h0000_000F_0FFF_FFFF); drain();
        issue(3'd2, 32'h1234, 32'd0, 64'd0, 1, 0, 1, 64'h0000_1234_FFFF_FFFF); drain();
        issue(3'd4, 32'd2, 32'd3, 64'h10, 1, 0, 1, 64'h16); drain();
        issue(3'd7, 32'd1, 32'd1, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF); drain();
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1, 0, 1, 64'h0000_0000_8000_0000); drain();

        // Flush at cycle 10 of a DIV: no done, unit idle next cycle.
        issue(3'd2, 32'd1000, 32'd3, 64'd0, 0, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_stall", 64'(stall), 64'd0);
        repeat (40) @(posedge clk);
        issue(3'd3, 32'd100, 32'd7, 64'd0, 1, 0, 1, 64'h0000_0002_0000_000E); drain();

        // Start together with flush in IDLE is dropped.
        @(posedge clk);
        #1 begin start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd4; b = 32'd4; end
        @(negedge clk);
        check("flush_start_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);

        // Start held through DONE yields exactly one done.
        d0 = done_cnt;
        issue(3'd0, 32'd5, 32'd6, 64'd0, 1, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        check("held_start_done_count", 64'(done_cnt - d0), 64'd1);
        drain();

        // Asynchronous reset in the middle of a multiply.
        issue(3'd0, 32'd9, 32'd9, 64'd0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_result", result, 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_dz", 64'(div_by_zero), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 120; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = ra & 32'hFF; rb = rb & 32'hF; end
                3: rb = rb >> 20;
                default: ;
            endcase
            issue(ro, ra, rb, {$urandom, $urandom}, 1, 0);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
